serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder: accepts two parallel operands and a carry-in through a valid/ready handshake, then adds them LSB-first through a single one-bit full adder and a carry flip-flop, one bit per clock. When all bits are processed, it presents the parallel sum and carry-out with a one-cycle done pulse. It is the addition counterpart of the team's one-bit subtractor, built as the area-minimal arithmetic engine for slow datapaths where one adder cell replaces N.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low; release is synchronous to clk.
- start_valid  input  1  request to start an addition.
- start_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  operand A; sampled only on accept.
- b  input  WIDTH  operand B; sampled only on accept.
- cin  input  1  carry-in; sampled only on accept.
- sum  output  WIDTH  result A+B+cin (mod 2^WIDTH); registered.
- cout  output  1  carry-out of bit WIDTH-1; registered.
- done  output  1  one-cycle pulse: sum/cout valid for the new result.
- busy  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- Accept = start_valid && start_ready, i.e. start_valid high in IDLE at a rising edge.
- On accept:
  - load a/b into shift registers sa/sb;
  - load cin into carry flop;
  - clear bit counter;
  - go to RUN.
- Each RUN cycle:
  - s = sa[0]^sb[0]^carry;
  - carry <= majority(sa[0], sb[0], carry);
  - sa, sb shift right one;
  - s enters the result shift register at the MSB (shift right);
  - counter increments.
- When the counter reaches WIDTH-1 in RUN, the next edge:
  - completes the last bit;
  - copies the result register to sum and the carry to cout;
  - moves to DONE.
- DONE lasts exactly one cycle with done=1, then IDLE unconditionally.
- sum/cout change only on the RUN→DONE edge and otherwise hold their value, including across later accepts until the next completion.
- start_valid outside IDLE is ignored; no queuing. Operands changing after accept have no effect.
- Counter width: $clog2(WIDTH). No overflow flag; the carry is reported in cout only.

## Timing
- Reset (async assert) values:
  - state=IDLE;
  - start_ready=1, busy=0, done=0;
  - sum=0, cout=0;
  - sa, sb, carry, counter, result register = 0.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately and no done pulse is produced. start_ready=1 from the first cycle after release.
- Latency: accept at edge E0 → RUN spans WIDTH edges (E1..E_WIDTH) → done=1 and the new sum/cout visible in the cycle after E_WIDTH.
- The next accept is possible at edge E_WIDTH+2. Throughput is one addition per WIDTH+2 cycles.
- start_ready and busy are registered state decodes, complementary in every cycle.
- Carry from a previous operation never leaks: carry is always reloaded from cin on accept.

## Structure
- Shared package serial_arith_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant;
  - reused by a planned serial subtractor.
- Sub-module full_adder_bit: combinational one-bit adder (a, b, ci → s, co), instantiated once. It is the only combinational arithmetic cell.
- The top contains the FSM, counter, three shift registers and the output registers.

## Test plan
- WIDTH=8, a=8'h05, b=8'h03, cin=0 → done exactly 8 cycles after the accept edge; sum=8'h08, cout=0; start_ready low throughout RUN/DONE.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- a=0, b=0, cin=1 → sum=8'h01, cout=0. Immediately after, a=0, b=0, cin=0 → sum=8'h00, cout=0 (no carry leakage).
- Hold start_valid high with a/b changing every cycle during RUN → only the accept-edge operands are used; exactly one done per accept; an accept occurs in the first IDLE cycle after done.
- Assert rst_n low after 4 RUN cycles of 8'hAA+8'h55 → all outputs at reset values, no done pulse. A new accept of 8'h10+8'h20 after release → sum=8'h30.
- Random sweep of 1000 operand/cin triples at WIDTH=8 and WIDTH=16 → {cout,sum} == a+b+cin for every operation, and the done count equals the accept count.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic engines (adder now, subtractor later).
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder; the single arithmetic cell of the serial engine.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are accepted in IDLE, summed LSB-first over
// WIDTH cycles through one full adder, then presented with a one-cycle done pulse.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;

    full_adder_bit u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_valid) next_state = ST_RUN;
            ST_RUN:  if (cnt == LAST) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == ST_IDLE);
        busy        = (state == ST_RUN) || (state == ST_DONE);
        done        = (state == ST_DONE);
    end

    // Result bits enter at the MSB so the finished word lines up after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == ST_IDLE && start_valid) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            res   <= {s, res[WIDTH-1:1]};
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
                sum  <= {s, res[WIDTH-1:1]};
                cout <= co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16: directed cases,
// reset abort, held-valid back-to-back accepts and a randomized sweep against a+b+cin.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        sv8, rdy8, ci8, co8, done8, busy8;
    logic [7:0]  a8, b8, sum8;
    logic        sv16, rdy16, ci16, co16, done16, busy16;
    logic [15:0] a16, b16, sum16;

    int checks = 0;
    int errors = 0;
    int ops8 = 0, ops16 = 0;
    int dones8 = 0, dones16 = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(rdy8),
        .a(a8), .b(b8), .cin(ci8), .sum(sum8), .cout(co8), .done(done8), .busy(busy8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(rdy16),
        .a(a16), .b(b16), .cin(ci16), .sum(sum16), .cout(co16), .done(done16), .busy(busy16)
    );

    always @(posedge clk) begin
        if (done8)  dones8++;
        if (done16) dones16++;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic f_ready(input int w);
        return (w == 8) ? rdy8 : rdy16;
    endfunction

    function automatic logic f_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic f_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [32:0] f_result(input int w);
        return (w == 8) ? {24'b0, co8, sum8} : {16'b0, co16, sum16};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [31:0] av,
                         input logic [31:0] bv, input logic ci);
        if (w == 8) begin
            sv8 = v; a8 = av[7:0]; b8 = bv[7:0]; ci8 = ci;
        end else begin
            sv16 = v; a16 = av[15:0]; b16 = bv[15:0]; ci16 = ci;
        end
    endtask

    task automatic wait_ready(input int w);
        int n;
        n = 0;
        @(negedge clk);
        while (!f_ready(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 64'(f_ready(w)), 64'd1);
    endtask

    // Called #1 after the accept edge; returns the number of edges until done is seen.
    task automatic wait_done(input int w, input bit jitter, output int lat, output bit stray);
        lat   = 0;
        stray = 1'b0;
        while (lat < 40 && !f_done(w)) begin
            if (f_ready(w) || !f_busy(w)) stray = 1'b1;
            if (jitter) drive(w, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
            lat++;
        end
        if (f_done(w) && (f_ready(w) || !f_busy(w))) stray = 1'b1;
    endtask

    task automatic check_output(input string tag, input int w, input logic [31:0] av,
                                input logic [31:0] bv, input logic ci,
                                input int lat, input bit stray);
        logic [32:0] mask;
        logic [32:0] expv;
        mask = (33'd1 << w) - 33'd1;
        expv = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + 33'(ci);
        check({tag, "_result"}, 64'(f_result(w)), 64'(expv));
        check({tag, "_latency"}, 64'(lat), 64'(w));
        check({tag, "_handshake"}, 64'(stray), 64'd0);
    endtask

    task automatic apply_stimulus(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic ci, input string tag);
        int lat;
        bit stray;
        wait_ready(w);
        drive(w, 1'b1, av, bv, ci);
        @(posedge clk);
        if (w == 8) ops8++; else ops16++;
        #1;
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        wait_done(w, 1'b0, lat, stray);
        check_output(tag, w, av, bv, ci, lat, stray);
    endtask

    initial begin
        int lat;
        bit stray;
        int d0;
        logic [31:0] x2, y2;

        rst_n = 1'b0;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(16, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(rdy8), 64'd1);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_result", 64'(f_result(8)), 64'd0);
        check("rst_result16", 64'(f_result(16)), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(rdy8), 64'd1);

        apply_stimulus(8, 32'h05, 32'h03, 1'b0, "add_05_03");
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done8), 64'd0);
        check("idle_after_done", 64'(rdy8), 64'd1);

        apply_stimulus(8, 32'hFF, 32'h01, 1'b0, "add_ff_01");
        apply_stimulus(8, 32'hFF, 32'hFF, 1'b1, "add_ff_ff_c");
        apply_stimulus(8, 32'h00, 32'h00, 1'b1, "add_0_0_c");
        apply_stimulus(8, 32'h00, 32'h00, 1'b0, "no_leak");

        // Valid held high with operands jittering while the engine runs.
        wait_ready(8);
        drive(8, 1'b1, 32'h3C, 32'h5A, 1'b1);
        @(posedge clk);
        ops8++;
        #1;
        d0 = dones8;
        wait_done(8, 1'b1, lat, stray);
        check_output("hold_first", 8, 32'h3C, 32'h5A, 1'b1, lat, stray);
        x2 = $urandom;
        y2 = $urandom;
        drive(8, 1'b1, x2, y2, 1'b0);
        @(posedge clk);
        #1;
        check("hold_idle_ready", 64'(rdy8), 64'd1);
        @(posedge clk);
        ops8++;
        #1;
        check("hold_reaccept", 64'(busy8), 64'd1);
        drive(8, 1'b0, $urandom, $urandom, 1'b1);
        wait_done(8, 1'b0, lat, stray);
        check_output("hold_second", 8, x2, y2, 1'b0, lat, stray);
        @(posedge clk);
        #1;
        check("hold_done_count", 64'(dones8 - d0), 64'd2);

        // Abort in mid-run: no done, outputs back at reset values.
        wait_ready(8);
        drive(8, 1'b1, 32'hAA, 32'h55, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        d0 = dones8;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", 64'(f_result(8)), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_ready", 64'(rdy8), 64'd1);
        check("abort_busy", 64'(busy8), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(dones8 - d0), 64'd0);
        apply_stimulus(8, 32'h10, 32'h20, 1'b0, "after_abort");

        for (int i = 0; i < 1000; i++)
            apply_stimulus(8, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand8");
        for (int i = 0; i < 1000; i++)
            apply_stimulus(16, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand16");

        repeat (4) @(posedge clk);
        #1;
        check("done_count8", 64'(dones8), 64'(ops8));
        check("done_count16", 64'(dones16), 64'(ops16));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
